mux_sel_reg_n: RTL and testbench
================================

# mux_sel_reg_n

Parametrised, registered N-way selector that generalises the team's 2:1 32-bit datapath mux into a handshaked stage with configurable width and channel count. Each cycle it grants one input channel, either by an explicit select or by round-robin arbitration, and captures that channel's word into a one-entry output register with valid/ready flow control. It sits between producers (ALU result, memory read data, PC+4, immediate) and the write-back/register-file consumer when the datapath is pipelined.

## Interface
Parameters:
- W, 32, data width in bits (>=1)
- N, 4, number of input channels (>=2)
- SELW, $clog2(N), select/channel-index width (derived; do not override)

Ports (clock and reset first):
- clk  input  1  single clock; all state on rising edge
- rst_n  input  1  asynchronous, active-low reset
- in_data  input  N*W  channel i occupies bits [i*W +: W]
- in_valid  input  N  per-channel valid
- in_ready  output  N  per-channel ready; at most one bit high per cycle
- sel  input  SELW  explicit channel select (explicit mode)
- mode  input  1  0 = explicit select, 1 = round-robin (see Configuration)
- out_data  output  W  registered selected word
- out_ch  output  SELW  index of channel that produced out_data
- out_valid  output  1  out_data/out_ch hold a valid word
- out_ready  input  1  consumer accepts the word

## Operation
- Reset values: out_valid=0, out_data=0, out_ch=0, round-robin pointer ptr=0.
- can_accept = !out_valid | out_ready.
- Explicit mode: grant = sel if sel < N and in_valid[sel]; otherwise no grant. sel >= N never grants and never raises any in_ready.
- Round-robin mode: grant = first i with in_valid[i], searching ptr, ptr+1, ..., N-1, 0, ..., ptr-1 (wrap modulo N). No valid input means no grant.
- in_ready[i] = can_accept & (i == candidate), where candidate is the channel selected by the active mode rule; in_ready is combinational from in_valid, sel, mode, ptr, out_valid, out_ready.
- Transfer on channel i when in_valid[i] & in_ready[i]: out_data <= in_data[i], out_ch <= i, out_valid <= 1.
- Drain without new transfer (out_valid & out_ready, no grant): out_valid <= 0; out_data and out_ch keep their last values.
- Stall (out_valid & !out_ready): out_data, out_ch, out_valid held stable; all in_ready low.
- ptr updates only on a round-robin transfer: ptr <= (grant == N-1) ? 0 : grant+1. Explicit-mode transfers leave ptr unchanged.
- mode/sel changes are sampled combinationally; they affect only the next grant, never a held word.

## Timing
- Latency 1 cycle: word accepted at edge k appears on out_data after edge k.
- Throughput 1 word/cycle when out_ready is held high (simultaneous drain and refill in the same cycle).
- No combinational path from in_data to out_data.
- rst_n assertion mid-operation clears out_valid and ptr immediately (asynchronously); the held word is discarded. Deassertion is synchronised externally.

## Configuration
- MUX_SEL_RR_EN defined: round-robin arbiter and ptr are compiled in; mode selects between explicit and round-robin.
- Not defined: arbiter and ptr are removed; the mode input remains on the port list but is ignored; the block behaves as explicit-select only.

## Structure
- Shared package mux_sel_pkg: mode constants MODE_EXPLICIT=1'b0 and MODE_RR=1'b1; the clog2-based SELW helper.
- One sub-module: rr_arbiter_n (N-bit request vector and pointer in, one-hot grant plus index out, purely combinational). It is instantiated only under MUX_SEL_RR_EN.

## Test plan
- Reset: rst_n=0 with arbitrary inputs -> out_valid=0, out_data=0, out_ch=0, in_ready=0; release, then sel=2, in_valid=4'b0100, in_data[2]=32'hDEADBEEF, out_ready=1 -> next cycle out_data=32'hDEADBEEF, out_ch=2, out_valid=1.
- Backpressure: out_valid=1, out_ready=0 for 3 cycles while in_valid=4'b1111 -> in_ready=0 and out_data stable; out_ready=1 -> refill in the same cycle and one transfer per cycle thereafter.
- Invalid select: N=3, sel=3, in_valid=3'b111 -> in_ready=0 and out_valid stays 0.
- Round-robin fairness (MUX_SEL_RR_EN): mode=1, in_valid=4'b1111 constant, out_ready=1 -> out_ch sequence 0,1,2,3,0; with in_valid=4'b1001 and ptr=1 -> grant 3, then 0.
- Wrap and mode switch: grant on channel N-1 -> ptr=0; switch to mode=0 mid-stream with sel=1 -> next out_ch=1 and ptr unchanged.
- Mid-operation reset: rst_n pulsed low during a stall with out_valid=1 -> out_valid=0 immediately and ptr=0; the first post-reset round-robin grant is channel 0.

Source files
------------

// File: rtl/mux_sel_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mux_sel_pkg
// Description : Shared constants and helpers for the registered N-way
//               selector (mode encodings, select-width helper).
// Revision    : 1.0 - initial release
// ============================================================================
package mux_sel_pkg;

  // Encoding of the mode input
  localparam logic MODE_EXPLICIT = 1'b0;
  localparam logic MODE_RR       = 1'b1;

  // Width of a channel index for an n-channel selector (n >= 2)
  function automatic int calc_selw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter_n.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter_n
// Description : Purely combinational round-robin arbiter. Searches the
//               request vector starting at ptr_i, wrapping modulo N, and
//               returns a one-hot grant, its index and an any-grant flag.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter_n
  import mux_sel_pkg::*;
#(
  parameter int N    = 4,
  parameter int SELW = calc_selw(N)
) (
  input  logic [N-1:0]    req_i,
  input  logic [SELW-1:0] ptr_i,
  output logic [N-1:0]    gnt_o,
  output logic [SELW-1:0] idx_o,
  output logic            any_o
);

  // Two passes: first the channels at or above the pointer, then the wrapped
  // ones below it; the first hit wins.
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!any_o && req_i[i] && (SELW'(i) >= ptr_i)) begin
        gnt_o[i] = 1'b1;
        idx_o    = SELW'(i);
        any_o    = 1'b1;
      end
    end
    for (int i = 0; i < N; i++) begin
      if (!any_o && req_i[i]) begin
        gnt_o[i] = 1'b1;
        idx_o    = SELW'(i);
        any_o    = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/mux_sel_reg_n.sv
`default_nettype none
// ============================================================================
// Module      : mux_sel_reg_n
// Description : Registered N-way selector with valid/ready handshake. Grants
//               one channel per cycle (explicit select or round-robin) into
//               a one-entry output register.
//               Optional feature macro: MUX_SEL_RR_EN (round-robin arbiter
//               and pointer; without it mode is ignored, explicit only).
// Revision    : 1.0 - initial release
// ============================================================================
module mux_sel_reg_n
  import mux_sel_pkg::*;
#(
  parameter int W    = 32,
  parameter int N    = 4,
  parameter int SELW = calc_selw(N)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N*W-1:0]    in_data,
  input  logic [N-1:0]      in_valid,
  output logic [N-1:0]      in_ready,
  input  logic [SELW-1:0]   sel,
  input  logic              mode,
  output logic [W-1:0]      out_data,
  output logic [SELW-1:0]   out_ch,
  output logic              out_valid,
  input  logic              out_ready
);

  logic [W-1:0]    out_data_q, out_data_d;
  logic [SELW-1:0] out_ch_q, out_ch_d;
  logic            out_valid_q, out_valid_d;

  logic [N-1:0]    w_exp_gnt;
  logic [SELW-1:0] w_exp_idx;
  logic            w_exp_any;

  logic [N-1:0]    w_gnt;
  logic [SELW-1:0] w_gnt_idx;
  logic            w_gnt_any;

  logic            w_can_accept;
  logic            w_xfer;
  logic [W-1:0]    w_word;

  // Explicit select: compare against every legal index so sel >= N matches nothing
  always_comb begin
    w_exp_gnt = '0;
    w_exp_idx = '0;
    for (int i = 0; i < N; i++) begin
      if ((sel == SELW'(i)) && in_valid[i]) begin
        w_exp_gnt[i] = 1'b1;
        w_exp_idx    = SELW'(i);
      end
    end
  end
  assign w_exp_any = |w_exp_gnt;

`ifdef MUX_SEL_RR_EN
  logic [SELW-1:0] ptr_q, ptr_d;
  logic [N-1:0]    w_rr_gnt;
  logic [SELW-1:0] w_rr_idx;
  logic            w_rr_any;

  rr_arbiter_n #(
    .N    (N),
    .SELW (SELW)
  ) u_rr_arbiter (
    .req_i (in_valid),
    .ptr_i (ptr_q),
    .gnt_o (w_rr_gnt),
    .idx_o (w_rr_idx),
    .any_o (w_rr_any)
  );

  // Active-mode grant selection
  always_comb begin
    if (mode == MODE_RR) begin
      w_gnt     = w_rr_gnt;
      w_gnt_idx = w_rr_idx;
      w_gnt_any = w_rr_any;
    end else begin
      w_gnt     = w_exp_gnt;
      w_gnt_idx = w_exp_idx;
      w_gnt_any = w_exp_any;
    end
  end

  // Pointer advances past the winner only on a round-robin transfer
  always_comb begin
    ptr_d = ptr_q;
    if (w_xfer && (mode == MODE_RR)) begin
      ptr_d = (w_gnt_idx == SELW'(N - 1)) ? '0 : w_gnt_idx + SELW'(1);
    end
  end

  // Round-robin pointer register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end
`else
  // Explicit-only build: mode stays on the port list but has no effect
  logic unused_mode;
  assign unused_mode = mode;
  assign w_gnt       = w_exp_gnt;
  assign w_gnt_idx   = w_exp_idx;
  assign w_gnt_any   = w_exp_any;
`endif

  assign w_can_accept = ~out_valid_q | out_ready;
  assign w_xfer       = w_can_accept & w_gnt_any;
  // Ready is held low while in reset so no producer sees a phantom handshake
  assign in_ready     = w_gnt & {N{w_can_accept & rst_n}};

  // Data mux driven by the one-hot grant
  always_comb begin
    w_word = '0;
    for (int i = 0; i < N; i++) begin
      if (w_gnt[i]) begin
        w_word = in_data[i*W +: W];
      end
    end
  end

  // Output register next state: refill, drain or hold
  always_comb begin
    out_data_d  = out_data_q;
    out_ch_d    = out_ch_q;
    out_valid_d = out_valid_q;
    if (w_xfer) begin
      out_data_d  = w_word;
      out_ch_d    = w_gnt_idx;
      out_valid_d = 1'b1;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // Output register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data_q  <= '0;
      out_ch_q    <= '0;
      out_valid_q <= 1'b0;
    end else begin
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_ch    = out_ch_q;
  assign out_valid = out_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_mux_sel_reg_n.sv
`default_nettype none
// ============================================================================
// Module      : tb_mux_sel_reg_n
// Description : Directed self-checking bench for mux_sel_reg_n (N=4/W=32
//               plus an N=3/W=8 instance for the out-of-range select).
//               Round-robin scenarios run when MUX_SEL_RR_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mux_sel_reg_n;

  logic         clk;
  logic         rst_n;
  logic [127:0] in_data;
  logic [3:0]   in_valid;
  logic [3:0]   in_ready;
  logic [1:0]   sel;
  logic         mode;
  logic [31:0]  out_data;
  logic [1:0]   out_ch;
  logic         out_valid;
  logic         out_ready;

  logic [23:0]  in_data3;
  logic [2:0]   in_valid3;
  logic [2:0]   in_ready3;
  logic [1:0]   sel3;
  logic [7:0]   out_data3;
  logic [1:0]   out_ch3;
  logic         out_valid3;
  logic         out_ready3;

  int errors = 0;
  int checks = 0;

  mux_sel_reg_n #(.W(32), .N(4)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .sel(sel), .mode(mode), .out_data(out_data),
    .out_ch(out_ch), .out_valid(out_valid), .out_ready(out_ready)
  );

  mux_sel_reg_n #(.W(8), .N(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data3), .in_valid(in_valid3),
    .in_ready(in_ready3), .sel(sel3), .mode(1'b0), .out_data(out_data3),
    .out_ch(out_ch3), .out_valid(out_valid3), .out_ready(out_ready3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; mode = 1'b0; sel = 2'd1; in_valid = 4'b1111; out_ready = 1'b0;
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got=%b exp=0", out_valid); end
    checks++; if (out_data !== 32'h0) begin errors++; $display("FAIL rst_data got=%h exp=0", out_data); end
    checks++; if (out_ch !== 2'd0) begin errors++; $display("FAIL rst_ch got=%0d exp=0", out_ch); end
    checks++; if (in_ready !== 4'b0000) begin errors++; $display("FAIL rst_in_ready got=%b exp=0000", in_ready); end
    checks++; if (out_valid3 !== 1'b0) begin errors++; $display("FAIL rst_valid3 got=%b exp=0", out_valid3); end
    rst_n = 1'b1;
    in_data[2*32 +: 32] = 32'hDEADBEEF;
    sel = 2'd2; in_valid = 4'b0100; out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 4'b0100) begin errors++; $display("FAIL first_ready got=%b exp=0100", in_ready); end
    tick();
    checks++; if (out_data !== 32'hDEADBEEF) begin errors++; $display("FAIL first_data got=%h exp=deadbeef", out_data); end
    checks++; if (out_ch !== 2'd2) begin errors++; $display("FAIL first_ch got=%0d exp=2", out_ch); end
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL first_valid got=%b exp=1", out_valid); end
    in_valid = 4'b0000;
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL drain_valid got=%b exp=0", out_valid); end
    checks++; if (out_data !== 32'hDEADBEEF) begin errors++; $display("FAIL drain_data_hold got=%h exp=deadbeef", out_data); end
    in_data[2*32 +: 32] = 32'hA000_0002;
  endtask

  task automatic test_backpressure();
    sel = 2'd1; in_valid = 4'b1111; out_ready = 1'b1;
    tick();
    checks++; if (out_data !== 32'hA000_0001) begin errors++; $display("FAIL bp_fill_data got=%h exp=a0000001", out_data); end
    out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++; if (in_ready !== 4'b0000) begin errors++; $display("FAIL bp_ready[%0d] got=%b exp=0000", c, in_ready); end
      tick();
      checks++; if (out_data !== 32'hA000_0001) begin errors++; $display("FAIL bp_data[%0d] got=%h exp=a0000001", c, out_data); end
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_valid[%0d] got=%b exp=1", c, out_valid); end
    end
    out_ready = 1'b1; sel = 2'd3;
    #1;
    checks++; if (in_ready !== 4'b1000) begin errors++; $display("FAIL bp_refill_ready got=%b exp=1000", in_ready); end
    tick();
    checks++; if (out_ch !== 2'd3 || out_data !== 32'hA000_0003) begin errors++; $display("FAIL bp_refill ch=%0d data=%h exp ch=3 data=a0000003", out_ch, out_data); end
    sel = 2'd0;
    tick();
    checks++; if (out_ch !== 2'd0 || out_data !== 32'hA000_0000) begin errors++; $display("FAIL b2b_0 ch=%0d data=%h exp ch=0 data=a0000000", out_ch, out_data); end
    sel = 2'd2;
    tick();
    checks++; if (out_ch !== 2'd2 || out_valid !== 1'b1) begin errors++; $display("FAIL b2b_2 ch=%0d valid=%b exp ch=2 valid=1", out_ch, out_valid); end
    in_valid = 4'b0000;
    tick();
  endtask

  task automatic test_invalid_sel();
    sel3 = 2'd3; in_valid3 = 3'b111; out_ready3 = 1'b1;
    #1;
    checks++; if (in_ready3 !== 3'b000) begin errors++; $display("FAIL inv_ready got=%b exp=000", in_ready3); end
    tick();
    checks++; if (out_valid3 !== 1'b0) begin errors++; $display("FAIL inv_valid got=%b exp=0", out_valid3); end
    sel3 = 2'd2;
    #1;
    checks++; if (in_ready3 !== 3'b100) begin errors++; $display("FAIL sel2_ready3 got=%b exp=100", in_ready3); end
    tick();
    checks++; if (out_ch3 !== 2'd2 || out_data3 !== 8'h33) begin errors++; $display("FAIL sel2_out3 ch=%0d data=%h exp ch=2 data=33", out_ch3, out_data3); end
    // Explicit select of a channel that is not valid grants nothing
    sel = 2'd1; in_valid = 4'b1101; out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 4'b0000) begin errors++; $display("FAIL novalid_ready got=%b exp=0000", in_ready); end
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL novalid_out got=%b exp=0", out_valid); end
  endtask

`ifndef MUX_SEL_RR_EN
  task automatic test_mode_ignored();
    mode = 1'b1; sel = 2'd2; in_valid = 4'b1111; out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 4'b0100) begin errors++; $display("FAIL modeign_ready got=%b exp=0100", in_ready); end
    tick();
    checks++; if (out_ch !== 2'd2) begin errors++; $display("FAIL modeign_ch got=%0d exp=2", out_ch); end
    sel = 2'd3;
    tick();
    checks++; if (out_ch !== 2'd3) begin errors++; $display("FAIL modeign_ch2 got=%0d exp=3", out_ch); end
    mode = 1'b0; in_valid = 4'b0000;
    tick();
  endtask
`else
  task automatic test_rr_fairness();
    logic [1:0] exp_seq [5];
    exp_seq = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    mode = 1'b1; in_valid = 4'b1111; out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      checks++; if (out_ch !== exp_seq[k]) begin errors++; $display("FAIL rr_seq[%0d] got=%0d exp=%0d", k, out_ch, exp_seq[k]); end
    end
    in_valid = 4'b1001;
    tick();
    checks++; if (out_ch !== 2'd3) begin errors++; $display("FAIL rr_1001_a got=%0d exp=3", out_ch); end
    tick();
    checks++; if (out_ch !== 2'd0) begin errors++; $display("FAIL rr_1001_b got=%0d exp=0", out_ch); end
  endtask

  task automatic test_wrap_mode_switch();
    mode = 1'b1; in_valid = 4'b1000; out_ready = 1'b1;
    tick();
    checks++; if (out_ch !== 2'd3) begin errors++; $display("FAIL wrap_ch got=%0d exp=3", out_ch); end
    mode = 1'b0; sel = 2'd1; in_valid = 4'b1111;
    tick();
    checks++; if (out_ch !== 2'd1 || out_data !== 32'hA000_0001) begin errors++; $display("FAIL switch_ch ch=%0d data=%h exp ch=1 data=a0000001", out_ch, out_data); end
    mode = 1'b1;
    tick();
    checks++; if (out_ch !== 2'd0) begin errors++; $display("FAIL ptr_kept got=%0d exp=0", out_ch); end
  endtask

  task automatic test_mid_reset();
    mode = 1'b1; in_valid = 4'b0010; out_ready = 1'b1;
    tick();
    checks++; if (out_ch !== 2'd1) begin errors++; $display("FAIL mr_setup got=%0d exp=1", out_ch); end
    out_ready = 1'b0; in_valid = 4'b1111;
    tick();
    checks++; if (out_valid !== 1'b1 || out_ch !== 2'd1) begin errors++; $display("FAIL mr_stall valid=%b ch=%0d exp valid=1 ch=1", out_valid, out_ch); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mr_async_valid got=%b exp=0", out_valid); end
    rst_n = 1'b1; out_ready = 1'b1;
    tick();
    checks++; if (out_ch !== 2'd0 || out_valid !== 1'b1) begin errors++; $display("FAIL mr_first_rr ch=%0d valid=%b exp ch=0 valid=1", out_ch, out_valid); end
    in_valid = 4'b0000; mode = 1'b0;
    tick();
  endtask
`endif

  initial begin
    for (int i = 0; i < 4; i++) in_data[i*32 +: 32] = 32'hA000_0000 + 32'(i);
    in_data3 = {8'h33, 8'h22, 8'h11};
    sel3 = 2'd3; in_valid3 = 3'b000; out_ready3 = 1'b1;
    test_reset();
    test_backpressure();
    test_invalid_sel();
`ifndef MUX_SEL_RR_EN
    test_mode_ignored();
`else
    test_rr_fairness();
    test_wrap_mode_switch();
    test_mid_reset();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
